// File: rtl/led_pattern_sched.sv
// led_pattern_sched: step timebase, built-in LED pattern sequencer and
// host override arbiter for the 4-bit board LED bank.
// Define LED_SCHED_HOST_EN to build in the host override (HOLD state);
// without it the host ports are ignored and ACK/BUSY are tied low.
module led_pattern_sched #(
  parameter int TICK_DIV = 200000,
  parameter int HOLD_W   = 8
) (
  input  logic              CLK_1US,
  input  logic              SYS_RST,
  input  logic [1:0]        MODE_SEL,
  input  logic              HOST_REQ,
  input  logic [3:0]        HOST_PAT,
  input  logic [HOLD_W-1:0] HOST_HOLD,
  output logic              HOST_ACK,
  output logic              HOST_BUSY,
  output logic              STEP_TICK,
  output logic [3:0]        LEDReg
);

  localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

`ifdef LED_SCHED_HOST_EN
  typedef enum logic [1:0] {ST_OFF = 2'd0, ST_RUN = 2'd1, ST_HOLD = 2'd2} state_t;
`else
  typedef enum logic {ST_OFF = 1'b0, ST_RUN = 1'b1} state_t;
`endif

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       mode_q;
  logic [2:0]       idx;
  logic [2:0]       idx_next;
  state_t           state_q;
  state_t           state_next;
  logic [3:0]       led_next;
  logic             mode_change;
  logic             advance;

`ifdef LED_SCHED_HOST_EN
  logic [3:0]        pat_q;
  logic [3:0]        pat_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;
  logic              grant;
`endif

  // LED image for a given mode and step index
  function automatic logic [3:0] pattern_of(input logic [1:0] mode, input logic [2:0] step);
    logic [3:0] p;
    p = 4'b0000;
    case (mode)
      2'b01: begin
        case (step[1:0])
          2'd0:    p = 4'b0001;
          2'd1:    p = 4'b1000;
          2'd2:    p = 4'b0100;
          default: p = 4'b0010;
        endcase
      end
      2'b10: p = step[0] ? 4'b0000 : 4'b1111;
      2'b11: begin
        case (step)
          3'd0:    p = 4'b0001;
          3'd1:    p = 4'b0010;
          3'd2:    p = 4'b0100;
          3'd3:    p = 4'b1000;
          3'd4:    p = 4'b0100;
          default: p = 4'b0010;
        endcase
      end
      default: p = 4'b0000;
    endcase
    return p;
  endfunction

  // Index of the last step of each pattern; idx wraps to 0 after it
  function automatic logic [2:0] last_of(input logic [1:0] mode);
    logic [2:0] l;
    case (mode)
      2'b01:   l = 3'd3;
      2'b10:   l = 3'd1;
      2'b11:   l = 3'd5;
      default: l = 3'd0;
    endcase
    return l;
  endfunction

  // Free-running step divider, 0..TICK_DIV-1
  always_ff @(posedge CLK_1US) begin
    if (SYS_RST) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign STEP_TICK = (div_cnt == DIV_LAST);

  // Next state, step index and LED image; the LED register is loaded from
  // the post-edge view (MODE_SEL becomes mode_q) so changes show one cycle later
  always_comb begin
    mode_change = (MODE_SEL != mode_q);
    state_next  = (MODE_SEL == 2'b00) ? ST_OFF : ST_RUN;
    idx_next    = idx;
    led_next    = 4'b0000;
    advance     = (state_q == ST_RUN) && STEP_TICK;
`ifdef LED_SCHED_HOST_EN
    grant     = 1'b0;
    pat_next  = pat_q;
    hold_next = hold_cnt;
    if (state_q == ST_HOLD) begin
      // Stay in HOLD unless the count is exhausted on a tick
      if (!(STEP_TICK && (hold_cnt == '0))) begin
        state_next = ST_HOLD;
        if (STEP_TICK) begin
          hold_next = hold_cnt - HOLD_W'(1);
        end
      end
    end else if (HOST_REQ) begin
      // Grant beats a coincident tick: no idx advance, no decrement
      grant      = 1'b1;
      state_next = ST_HOLD;
      pat_next   = HOST_PAT;
      hold_next  = HOST_HOLD;
      advance    = 1'b0;
    end
`endif
    if (mode_change) begin
      idx_next = 3'd0;
    end else if (advance) begin
      idx_next = (idx == last_of(mode_q)) ? 3'd0 : idx + 3'd1;
    end
    case (state_next)
      ST_RUN:  led_next = pattern_of(MODE_SEL, idx_next);
`ifdef LED_SCHED_HOST_EN
      ST_HOLD: led_next = pat_next;
`endif
      default: led_next = 4'b0000;
    endcase
  end

  // State, mode, step index and LED registers
  always_ff @(posedge CLK_1US) begin
    if (SYS_RST) begin
      state_q <= ST_OFF;
      mode_q  <= 2'b00;
      idx     <= 3'd0;
      LEDReg  <= 4'b0000;
    end else begin
      state_q <= state_next;
      mode_q  <= MODE_SEL;
      idx     <= idx_next;
      LEDReg  <= led_next;
    end
  end

`ifdef LED_SCHED_HOST_EN
  // Override pattern, remaining hold steps and the one-cycle grant pulse
  always_ff @(posedge CLK_1US) begin
    if (SYS_RST) begin
      pat_q    <= 4'b0000;
      hold_cnt <= '0;
      HOST_ACK <= 1'b0;
    end else begin
      pat_q    <= pat_next;
      hold_cnt <= hold_next;
      HOST_ACK <= grant;
    end
  end

  assign HOST_BUSY = (state_q == ST_HOLD);
`else
  logic host_unused;
  assign host_unused = ^{HOST_REQ, HOST_PAT, HOST_HOLD};
  assign HOST_ACK    = 1'b0;
  assign HOST_BUSY   = 1'b0;
`endif

endmodule
